// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding for the configuration-chain loader.
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_e;
endpackage

// File: rtl/ccff_readback_packer.sv
// ccff_readback_packer: packs bits leaving the chain tail into left-aligned readback words.
module ccff_readback_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en_i,
  input  logic              last_bit_i,
  input  logic              clr_i,
  input  logic              tail_i,
  output logic [DATA_W-1:0] rb_data_o,
  output logic              rb_valid_o
);
  localparam int CW = $clog2(DATA_W);
  logic [DATA_W-1:0] sreg_q, sreg_d, rb_data_q;
  logic [CW-1:0] cnt_q;
  logic rb_valid_q, fire;
  assign sreg_d = {sreg_q[DATA_W-2:0], tail_i};
  assign fire = shift_en_i && (cnt_q == CW'(DATA_W - 1) || last_bit_i);
  assign rb_data_o = rb_data_q;
  assign rb_valid_o = rb_valid_q;
  // A short final word is shifted up so its first-captured bit lands in the MSB.
  always_ff @(posedge clk)
    if (rst) begin
      sreg_q <= '0;
      cnt_q <= '0;
      rb_data_q <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= fire;
      if (clr_i) begin
        sreg_q <= '0;
        cnt_q <= '0;
      end else if (shift_en_i) begin
        sreg_q <= fire ? '0 : sreg_d;
        cnt_q <= fire ? '0 : cnt_q + 1'b1;
        if (fire) rb_data_q <= sreg_d << (CW'(DATA_W - 1) - cnt_q);
      end
    end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises bitstream words MSB-first into the config chain and gates its clock.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);
  localparam int WL_W = $clog2(DATA_W + 1);
  state_e state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [WL_W-1:0] word_left_q;
  logic [CNT_W-1:0] bit_count_q;
  logic shifting, last_bit, load_start;
  assign shifting = state_q == SHIFT;
  assign last_bit = shifting && bit_count_q == CNT_W'(CHAIN_LEN - 1);
  assign load_start = start && (state_q == IDLE || state_q == DONE);
  // Every output decodes registered state only, so the ICG enable never sees input glitches.
  assign bs_ready = state_q == FETCH;
  assign cfg_clk_en = shifting;
  assign ccff_head = shifting && sreg_q[DATA_W-1];
  assign busy = state_q == FETCH || shifting;
  assign done = state_q == DONE;
  assign bit_count = bit_count_q;
  always_ff @(posedge prog_clk)
    if (pReset) begin
      state_q <= IDLE;
      sreg_q <= '0;
      word_left_q <= '0;
      bit_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (load_start) begin
          state_q <= FETCH;
          bit_count_q <= '0;
        end
        FETCH: if (bs_valid) begin
          sreg_q <= bs_data;
          word_left_q <= WL_W'(DATA_W);
          state_q <= SHIFT;
        end
        SHIFT: begin
          sreg_q <= sreg_q << 1;
          word_left_q <= word_left_q - 1'b1;
          bit_count_q <= bit_count_q + 1'b1;
          state_q <= last_bit ? DONE : word_left_q == WL_W'(1) ? FETCH : SHIFT;
        end
      endcase
    end
  ccff_readback_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (prog_clk),
    .rst        (pReset),
    .shift_en_i (shifting),
    .last_bit_i (last_bit),
    .clr_i      (load_start),
    .tail_i     (ccff_tail),
    .rb_data_o  (rb_data),
    .rb_valid_o (rb_valid)
  );
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: two loaders (64-flop and 40-flop chains) against a bench-side chain model.
module tb_ccff_bitstream_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [1:0] start = '0, bs_valid = '0;
  logic [1:0] bs_ready, head, tail, en, rb_valid, busy, done;
  logic [31:0] bs_data [2];
  logic [63:0] rb_bus;
  logic [6:0] bc_a;
  logic [5:0] bc_b;
  logic [63:0] chain0 = '0;
  logic [39:0] chain1 = '0;
  logic [31:0] wq [2][$];
  int sq [2][$];
  int stall_left [2];
  bit hs_pend [2];
  int en_cnt [2], fetch_cnt [2], hs_cnt [2];
  logic [63:0] head_acc [2];
  logic [31:0] rbq [2][$];
  int errors = 0, checks = 0;

  assign tail = {chain1[39], chain0[63]};
  always @(posedge clk) if (en[0]) chain0 <= {chain0[62:0], head[0]};
  always @(posedge clk) if (en[1]) chain1 <= {chain1[38:0], head[1]};

  ccff_bitstream_loader #(.CHAIN_LEN(64), .DATA_W(32)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(start[0]), .bs_data(bs_data[0]), .bs_valid(bs_valid[0]),
    .bs_ready(bs_ready[0]), .ccff_head(head[0]), .ccff_tail(tail[0]), .cfg_clk_en(en[0]),
    .rb_data(rb_bus[31:0]), .rb_valid(rb_valid[0]), .busy(busy[0]), .done(done[0]), .bit_count(bc_a));
  ccff_bitstream_loader #(.CHAIN_LEN(40), .DATA_W(32)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(start[1]), .bs_data(bs_data[1]), .bs_valid(bs_valid[1]),
    .bs_ready(bs_ready[1]), .ccff_head(head[1]), .ccff_tail(tail[1]), .cfg_clk_en(en[1]),
    .rb_data(rb_bus[63:32]), .rb_valid(rb_valid[1]), .busy(busy[1]), .done(done[1]), .bit_count(bc_b));

  // Word source with per-word stall counts, plus per-cycle observation at the falling edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      bs_data[k] = '0;
      stall_left[k] = 0;
      hs_pend[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (hs_pend[k]) begin
          void'(wq[k].pop_front());
          stall_left[k] = 0;
          if (sq[k].size() > 0) stall_left[k] = sq[k].pop_front();
        end
        if (bs_ready[k] && stall_left[k] > 0) begin
          bs_valid[k] = 1'b0;
          stall_left[k]--;
        end else bs_valid[k] = wq[k].size() > 0 && stall_left[k] == 0;
        bs_data[k] = wq[k].size() > 0 ? wq[k][0] : $urandom;
        hs_pend[k] = bs_valid[k] && bs_ready[k];
        if (hs_pend[k]) hs_cnt[k]++;
        if (en[k]) begin
          en_cnt[k]++;
          head_acc[k] = {head_acc[k][62:0], head[k]};
        end
        if (busy[k] && !en[k]) fetch_cnt[k]++;
        if (rb_valid[k]) rbq[k].push_back(k ? rb_bus[63:32] : rb_bus[31:0]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon(input int k);
    en_cnt[k] = 0;
    fetch_cnt[k] = 0;
    hs_cnt[k] = 0;
    head_acc[k] = '0;
    rbq[k].delete();
  endtask

  task automatic push_load(input int k, input logic [31:0] w0, input logic [31:0] w1, input int s0, input int s1);
    wq[k].push_back(w0);
    wq[k].push_back(w1);
    sq[k].delete();
    sq[k].push_back(s1);
    stall_left[k] = s0;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (done[k]) ok = 1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout dut=%0d got=0 exp=1", k);
    end
  endtask

  task automatic wait_bc_a(input int n);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (bc_a == 7'(n)) ok = 1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bit_count_timeout got=%0d exp=%0d", bc_a, n);
    end
  endtask

  task automatic run_load(input int k, input logic [31:0] w0, input logic [31:0] w1, input int s0, input int s1);
    clear_mon(k);
    push_load(k, w0, w1, s0, s1);
    pulse_start(k);
    wait_done(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks += 9;
    if (bs_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_bs_ready got=%b exp=0", bs_ready[0]); end
    if (en[0] !== 1'b0) begin errors++; $display("FAIL rst_cfg_clk_en got=%b exp=0", en[0]); end
    if (rb_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_rb_valid got=%b exp=0", rb_valid[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    if (done[0] !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done[0]); end
    if (bc_a !== 7'd0) begin errors++; $display("FAIL rst_bit_count got=%0d exp=0", bc_a); end
    if (head[0] !== 1'b0) begin errors++; $display("FAIL rst_ccff_head got=%b exp=0", head[0]); end
    if (rb_bus[31:0] !== 32'd0) begin errors++; $display("FAIL rst_rb_data got=%h exp=0", rb_bus[31:0]); end
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL rst_busy_b got=%b exp=0", busy[1]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    run_load(0, 32'hDEADBEEF, 32'h01234567, 0, 0);
    checks += 7;
    if (en_cnt[0] != 64) begin errors++; $display("FAIL b2b_en_cycles got=%0d exp=64", en_cnt[0]); end
    if (fetch_cnt[0] != 2) begin errors++; $display("FAIL b2b_fetch_cycles got=%0d exp=2", fetch_cnt[0]); end
    if (hs_cnt[0] != 2) begin errors++; $display("FAIL b2b_handshakes got=%0d exp=2", hs_cnt[0]); end
    if (bc_a !== 7'd64) begin errors++; $display("FAIL b2b_bit_count got=%0d exp=64", bc_a); end
    if (chain0 !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL b2b_chain got=%h exp=deadbeef01234567", chain0); end
    if (busy[0] !== 1'b0 || en[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_outs got=%b%b exp=00", busy[0], en[0]); end
    if (rbq[0].size() != 2) begin errors++; $display("FAIL b2b_rb_count got=%0d exp=2", rbq[0].size()); end
  endtask

  task automatic test_stall();
    run_load(0, 32'hDEADBEEF, 32'h01234567, 0, 10);
    checks += 5;
    if (en_cnt[0] != 64) begin errors++; $display("FAIL stall_en_cycles got=%0d exp=64", en_cnt[0]); end
    if (fetch_cnt[0] != 12) begin errors++; $display("FAIL stall_fetch_cycles got=%0d exp=12", fetch_cnt[0]); end
    if (chain0 !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL stall_chain got=%h exp=deadbeef01234567", chain0); end
    if (rbq[0].size() != 2) begin errors++; $display("FAIL stall_rb_count got=%0d exp=2", rbq[0].size()); end
    else if (rbq[0][0] !== 32'hDEADBEEF || rbq[0][1] !== 32'h01234567) begin
      errors++;
      $display("FAIL stall_readback got=%h_%h exp=deadbeef_01234567", rbq[0][0], rbq[0][1]);
    end
  endtask

  task automatic test_partial();
    run_load(1, 32'hA5A5A5A5, 32'hFF000000, 0, 0);
    checks += 5;
    if (hs_cnt[1] != 2) begin errors++; $display("FAIL part_handshakes got=%0d exp=2", hs_cnt[1]); end
    if (en_cnt[1] != 40) begin errors++; $display("FAIL part_en_cycles got=%0d exp=40", en_cnt[1]); end
    if (head_acc[1] !== 64'h00A5A5A5A5FF) begin errors++; $display("FAIL part_head_bits got=%h exp=a5a5a5a5ff", head_acc[1]); end
    if (chain1 !== 40'hA5A5A5A5FF) begin errors++; $display("FAIL part_chain got=%h exp=a5a5a5a5ff", chain1); end
    if (bc_b !== 6'd40) begin errors++; $display("FAIL part_bit_count got=%0d exp=40", bc_b); end
  endtask

  task automatic test_readback();
    run_load(0, 32'h0, 32'h0, 0, 0);
    run_load(1, 32'h0, 32'h0, 0, 0);
    checks += 4;
    if (rbq[0].size() != 2) begin errors++; $display("FAIL rb_a_count got=%0d exp=2", rbq[0].size()); end
    else if (rbq[0][0] !== 32'hDEADBEEF || rbq[0][1] !== 32'h01234567) begin
      errors++;
      $display("FAIL rb_a_words got=%h_%h exp=deadbeef_01234567", rbq[0][0], rbq[0][1]);
    end
    if (rbq[1].size() != 2) begin errors++; $display("FAIL rb_b_count got=%0d exp=2", rbq[1].size()); end
    else if (rbq[1][0] !== 32'hA5A5A5A5 || rbq[1][1] !== 32'hFF000000) begin
      errors++;
      $display("FAIL rb_b_words got=%h_%h exp=a5a5a5a5_ff000000", rbq[1][0], rbq[1][1]);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w0 = $urandom, w1 = $urandom, r0 = $urandom, r1 = $urandom;
    logic [63:0] prev;
    clear_mon(0);
    push_load(0, w0, w1, 0, 0);
    pulse_start(0);
    wait_bc_a(17);
    rst = 1'b1;
    tick();
    checks += 8;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy[0]); end
    if (en[0] !== 1'b0) begin errors++; $display("FAIL mrst_cfg_clk_en got=%b exp=0", en[0]); end
    if (bs_ready[0] !== 1'b0) begin errors++; $display("FAIL mrst_bs_ready got=%b exp=0", bs_ready[0]); end
    if (done[0] !== 1'b0) begin errors++; $display("FAIL mrst_done got=%b exp=0", done[0]); end
    if (bc_a !== 7'd0) begin errors++; $display("FAIL mrst_bit_count got=%0d exp=0", bc_a); end
    if (head[0] !== 1'b0) begin errors++; $display("FAIL mrst_ccff_head got=%b exp=0", head[0]); end
    if (rb_bus[31:0] !== 32'd0) begin errors++; $display("FAIL mrst_rb_data got=%h exp=0", rb_bus[31:0]); end
    prev = 64'(w0 >> 14);
    if (chain0 !== prev) begin errors++; $display("FAIL mrst_partial_chain got=%h exp=%h", chain0, prev); end
    rst = 1'b0;
    wq[0].delete();
    sq[0].delete();
    stall_left[0] = 0;
    hs_pend[0] = 0;
    tick();
    run_load(0, r0, r1, 0, 0);
    checks += 2;
    if (chain0 !== {r0, r1}) begin errors++; $display("FAIL mrst_reload_chain got=%h exp=%h", chain0, {r0, r1}); end
    if (rbq[0].size() != 2 || rbq[0][0] !== prev[63:32] || rbq[0][1] !== prev[31:0]) begin
      errors++;
      $display("FAIL mrst_readback got_count=%0d exp=%h", rbq[0].size(), prev);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] w0 = $urandom, w1 = $urandom, r0 = $urandom, r1 = $urandom;
    clear_mon(0);
    push_load(0, w0, w1, 0, 0);
    pulse_start(0);
    wait_bc_a(10);
    pulse_start(0);
    checks += 2;
    if (bc_a !== 7'd11) begin errors++; $display("FAIL shift_start_bit_count got=%0d exp=11", bc_a); end
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL shift_start_busy got=%b exp=1", busy[0]); end
    wait_done(0);
    checks += 2;
    if (chain0 !== {w0, w1}) begin errors++; $display("FAIL shift_start_chain got=%h exp=%h", chain0, {w0, w1}); end
    if (en_cnt[0] != 64) begin errors++; $display("FAIL shift_start_en_cycles got=%0d exp=64", en_cnt[0]); end
    clear_mon(0);
    pulse_start(0);
    checks += 3;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL done_start_done got=%b exp=0", done[0]); end
    if (bc_a !== 7'd0) begin errors++; $display("FAIL done_start_bit_count got=%0d exp=0", bc_a); end
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL done_start_busy got=%b exp=1", busy[0]); end
    push_load(0, r0, r1, 0, 0);
    wait_done(0);
    checks++;
    if (chain0 !== {r0, r1}) begin errors++; $display("FAIL done_start_chain got=%h exp=%h", chain0, {r0, r1}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int k = int'($urandom_range(0, 1));
      int len = k ? 40 : 64;
      int s0 = int'($urandom_range(0, 5)), s1 = int'($urandom_range(0, 5));
      logic [31:0] w0 = $urandom, w1 = $urandom;
      logic [63:0] prev = k ? {chain1, 24'd0} : chain0;
      logic [63:0] exp_chain = {w0, w1} >> (64 - len);
      logic [63:0] got_chain = k ? 64'(chain1) : chain0;
      run_load(k, w0, w1, s0, s1);
      got_chain = k ? 64'(chain1) : chain0;
      checks += 5;
      if (got_chain !== exp_chain) begin errors++; $display("FAIL rnd_chain dut=%0d got=%h exp=%h", k, got_chain, exp_chain); end
      if (en_cnt[k] != len) begin errors++; $display("FAIL rnd_en_cycles dut=%0d got=%0d exp=%0d", k, en_cnt[k], len); end
      if (fetch_cnt[k] != 2 + s0 + s1) begin errors++; $display("FAIL rnd_fetch dut=%0d got=%0d exp=%0d", k, fetch_cnt[k], 2 + s0 + s1); end
      if (hs_cnt[k] != 2) begin errors++; $display("FAIL rnd_handshakes dut=%0d got=%0d exp=2", k, hs_cnt[k]); end
      if (rbq[k].size() != 2 || rbq[k][0] !== prev[63:32] || rbq[k][1] !== prev[31:0]) begin
        errors++;
        $display("FAIL rnd_readback dut=%0d got_count=%0d exp=%h", k, rbq[k].size(), prev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_partial();
    test_readback();
    test_mid_reset();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
